// File: rtl/nes_controller_reader.sv
// NES joypad poller: periodically latches the controller, clocks out its eight
// serial bits and publishes them as an active-high, registered button vector.
module nes_controller_reader #(
    parameter int TICK_DIV   = 150,
    parameter int IDLE_TICKS = 2700
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nes_data,
    output logic       nes_clk,
    output logic       nes_latch,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       paddle_up,
    output logic       paddle_down
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(IDLE_TICKS + 1);

    typedef enum logic [1:0] {IDLE, LATCH, LOW, HIGH} state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [IW-1:0] idle_cnt;
    logic          latch_cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shift;
    logic          data_p0;
    logic          data_p1;

    // Serial bits arrive A first; the output vector holds A in the MSB and the
    // controller reports pressed buttons as 0.
    function automatic logic [7:0] to_buttons(input logic [7:0] s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[7-i] = ~s[i];
        end
        return b;
    endfunction

    // Stage boundary: controller data resynchronized into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            data_p0 <= 1'b1;
            data_p1 <= 1'b1;
        end else begin
            data_p0 <= nes_data;
            data_p1 <= data_p0;
        end
    end

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Protocol FSM; latch and clk outputs are set from the next state so both are glitch-free
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idle_cnt      <= '0;
            latch_cnt     <= 1'b0;
            bit_idx       <= 4'd0;
            shift         <= 8'h00;
            buttons       <= 8'h00;
            buttons_valid <= 1'b0;
            nes_latch     <= 1'b0;
            nes_clk       <= 1'b0;
        end else begin
            buttons_valid <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (idle_cnt == IW'(IDLE_TICKS - 1)) begin
                            idle_cnt  <= '0;
                            latch_cnt <= 1'b0;
                            nes_latch <= 1'b1;
                            state     <= LATCH;
                        end else begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                    end
                    LATCH: begin
                        if (latch_cnt) begin
                            shift[0]  <= data_p1;
                            bit_idx   <= 4'd1;
                            nes_latch <= 1'b0;
                            state     <= LOW;
                        end else begin
                            latch_cnt <= 1'b1;
                        end
                    end
                    LOW: begin
                        if (bit_idx <= 4'd7) begin
                            nes_clk <= 1'b1;
                            state   <= HIGH;
                        end else begin
                            buttons       <= to_buttons(shift);
                            buttons_valid <= 1'b1;
                            bit_idx       <= 4'd0;
                            state         <= IDLE;
                        end
                    end
                    HIGH: begin
                        shift[bit_idx[2:0]] <= data_p1;
                        bit_idx             <= bit_idx + 4'd1;
                        nes_clk             <= 1'b0;
                        state               <= LOW;
                    end
                    default: begin
                        nes_latch <= 1'b0;
                        nes_clk   <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

    assign paddle_up   = buttons[3];
    assign paddle_down = buttons[2];

endmodule
